// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer.
// Operation codes from the control FSM and sequencer state encoding.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_RUN   = 2'b10,
    S_FIN   = 2'b11
  } state_e;

  // HI/LO pair produced by one operation
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

endpackage

// File: rtl/muldiv_ctrl.sv
// HI/LO sequencer: launches the iterative multiply/divide units,
// waits for completion with a timeout and commits results to HI/LO.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic             mult_start,
  output logic             div_start,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic             mult_done,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_rem,
  input  logic [WIDTH-1:0] div_quo,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q,
  output logic             done,
  output logic             div_zero,
  output logic             timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  op_e              op_in;
  logic             unit_done;

  assign op_in = op_e'(op);

  // Only the unit that was launched may end the RUN phase
  assign unit_done = (op_q == OP_MULT) ? mult_done : div_done;

  // Sequencer FSM; every output is registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= OP_MULT;
      cnt_q       <= '0;
      ready       <= 1'b0;
      busy        <= 1'b0;
      mult_start  <= 1'b0;
      div_start   <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      done        <= 1'b0;
      div_zero    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      mult_start  <= 1'b0;
      div_start   <= 1'b0;
      done        <= 1'b0;
      div_zero    <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          if (req && ready) begin
            op_q  <= op_in;
            op_a  <= a_in;
            op_b  <= b_in;
            ready <= 1'b0;
            busy  <= 1'b1;
            unique case (op_in)
              OP_MTHI: begin
                hi_q    <= a_in;
                done    <= 1'b1;
                state_q <= S_FIN;
              end
              OP_MTLO: begin
                lo_q    <= a_in;
                done    <= 1'b1;
                state_q <= S_FIN;
              end
              OP_DIV: begin
                if (b_in == '0) begin
                  div_zero <= 1'b1;
                  done     <= 1'b1;
                  state_q  <= S_FIN;
                end else begin
                  div_start <= 1'b1;
                  state_q   <= S_START;
                end
              end
              OP_MULT: begin
                mult_start <= 1'b1;
                state_q    <= S_START;
              end
            endcase
          end
        end
        S_START: begin
          cnt_q   <= '0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (unit_done) begin
            if (op_q == OP_MULT) begin
              hi_q <= mult_hi;
              lo_q <= mult_lo;
            end else begin
              hi_q <= div_rem;
              lo_q <= div_quo;
            end
            done    <= 1'b1;
            state_q <= S_FIN;
          end else if (cnt_q == CNT_LAST) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state_q     <= S_FIN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_FIN: begin
          ready   <= 1'b1;
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
